// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and defaults for the countdown scheduler
package countdown_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/countdown_scheduler_rr_pick.sv
// rtl/countdown_scheduler_rr_pick.sv - combinational round-robin picker, searches upward from ptr
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             valid
);

    int idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/countdown_scheduler.sv
// rtl/countdown_scheduler.sv - one countdown timer shared among N_REQ requesters via round-robin
module countdown_scheduler
    import countdown_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    input  logic                   abort,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0] pick_win;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // grant/done are Mealy and gated by ~rst so a reset cycle never shows a pulse
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        grant    = '0;
        done     = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid && !abort) begin
                    grant    = pick_win & {N_REQ{~rst}};
                    cnt_d    = req_len[int'(pick_idx)*CNT_W +: CNT_W];
                    owner_d  = pick_idx;
                    rr_ptr_d = PTR_W'((int'(pick_idx) + 1) % N_REQ);
                    state_d  = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done[owner_q] = ~rst;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_countdown_scheduler.sv
// tb/tb_countdown_scheduler.sv - directed self-checking bench for countdown_scheduler
module tb_countdown_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_len;
    logic        abort;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    countdown_scheduler #(.N_REQ(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_len (req_len),
        .abort   (abort),
        .grant   (grant),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // next cycle: inputs change on the falling edge, outputs are sampled 1ns later
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic outs(input string tag, input logic [3:0] g, input logic [3:0] d, input logic b);
        chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
        chk({tag, ".done"},  {28'd0, done},  {28'd0, d});
        chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
    endtask

    logic [3:0] reqv;
    logic [3:0] g;

    initial begin
        rst = 1'b1; req = 4'b0001; req_len = '0; abort = 1'b0;

        // reset, with a request pending: nothing may pulse
        tick(); settle(); outs("rst0", 4'b0000, 4'b0000, 1'b0);
        tick(); settle(); outs("rst1", 4'b0000, 4'b0000, 1'b0);

        // T1: single request, len=3
        tick(); rst = 1'b0; req = 4'b0001; req_len = 32'h0000_0003;
        settle(); outs("t1.t0", 4'b0001, 4'b0000, 1'b0);
        tick(); req = 4'b0000; settle(); outs("t1.t1", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t1.t2", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t1.t3", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t1.t4", 4'b0000, 4'b0001, 1'b1);
        tick(); settle(); outs("t1.t5", 4'b0000, 4'b0000, 1'b0);

        // reset to bring rr_ptr back to 0
        rst = 1'b1; tick(); tick(); rst = 1'b0;

        // T2: all four requesting, len=0: grants every 2 cycles in order 0,1,2,3,0
        req_len = '0; reqv = 4'b1111; req = reqv;
        for (int i = 0; i < 5; i++) begin
            g = 4'b0001 << (i % 4);
            settle(); outs($sformatf("t2.grant%0d", i), g, 4'b0000, 1'b0);
            tick();
            reqv = reqv & ~g;
            if (i == 3) reqv = reqv | 4'b0001;
            req = reqv;
            settle(); outs($sformatf("t2.done%0d", i), 4'b0000, g, 1'b1);
            tick();
        end
        req = 4'b0000;

        // T3: abort in idle blocks grant; abort mid-count cancels; rr_ptr is now 1
        req = 4'b0100; req_len = 32'h0005_0000; abort = 1'b1;
        settle(); outs("t3.idle_abort", 4'b0000, 4'b0000, 1'b0);
        tick(); abort = 1'b0; settle(); outs("t3.t0", 4'b0100, 4'b0000, 1'b0);
        tick(); req = 4'b0000; settle(); outs("t3.t1", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t3.t2", 4'b0000, 4'b0000, 1'b1);
        tick(); abort = 1'b1; settle(); outs("t3.t3", 4'b0000, 4'b0000, 1'b1);
        tick(); abort = 1'b0; req = 4'b0001; settle(); outs("t3.t4", 4'b0001, 4'b0000, 1'b0);
        tick(); req = 4'b0000; settle(); outs("t3.t5", 4'b0000, 4'b0001, 1'b1);
        tick(); settle(); outs("t3.t6", 4'b0000, 4'b0000, 1'b0);

        // abort coincident with cnt==0 wins over done; rr_ptr is 1
        req = 4'b0010; req_len = '0;
        settle(); outs("t3b.t0", 4'b0010, 4'b0000, 1'b0);
        tick(); req = 4'b0000; abort = 1'b1; settle(); outs("t3b.t1", 4'b0000, 4'b0000, 1'b1);
        tick(); abort = 1'b0; settle(); outs("t3b.t2", 4'b0000, 4'b0000, 1'b0);

        // T4: rst mid-count; rr_ptr is 2 so requester 3 wins
        req = 4'b1000; req_len = 32'h0A00_0000;
        settle(); outs("t4.t0", 4'b1000, 4'b0000, 1'b0);
        tick(); req = 4'b0000; settle(); outs("t4.t1", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t4.t2", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t4.t3", 4'b0000, 4'b0000, 1'b1);
        tick(); rst = 1'b1; req = 4'b0001; settle(); outs("t4.rst", 4'b0000, 4'b0000, 1'b1);
        tick(); rst = 1'b0; req = 4'b1111; req_len = 32'h0A00_0000;
        settle(); outs("t4.after", 4'b0001, 4'b0000, 1'b0);
        tick(); req = 4'b0000; settle(); outs("t4.done0", 4'b0000, 4'b0001, 1'b1);
        tick(); settle(); outs("t4.idle", 4'b0000, 4'b0000, 1'b0);

        // T5: max length 255 on requester 1 (rr_ptr is 1): done exactly 256 cycles after grant
        req = 4'b0010; req_len = 32'h0000_FF00;
        settle(); outs("t5.t0", 4'b0010, 4'b0000, 1'b0);
        tick(); req = 4'b0000;
        for (int k = 1; k < 256; k++) begin
            settle(); outs($sformatf("t5.t%0d", k), 4'b0000, 4'b0000, 1'b1);
            tick();
        end
        settle(); outs("t5.t256", 4'b0000, 4'b0010, 1'b1);
        tick(); settle(); outs("t5.t257", 4'b0000, 4'b0000, 1'b0);
        tick(); settle(); outs("t5.t258", 4'b0000, 4'b0000, 1'b0);

        // T6: rr_ptr is 2; req1 pulsed while busy then dropped; len changed after grant
        req = 4'b0100; req_len = 32'h0003_0000;
        settle(); outs("t6.t0", 4'b0100, 4'b0000, 1'b0);
        tick(); req = 4'b0010; req_len = 32'h0009_0000; settle(); outs("t6.t1", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t6.t2", 4'b0000, 4'b0000, 1'b1);
        tick(); req = 4'b0000; settle(); outs("t6.t3", 4'b0000, 4'b0000, 1'b1);
        tick(); settle(); outs("t6.t4", 4'b0000, 4'b0100, 1'b1);
        tick(); settle(); outs("t6.t5", 4'b0000, 4'b0000, 1'b0);
        tick(); settle(); outs("t6.t6", 4'b0000, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
